alu_iterative: RTL



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_single_cycle.sv | 27 ++
 rtl/alu_iterative.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and FSM state encoding.
// The ALU-control decoder and the iterative ALU both import these codes.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } alu_state_e;

    // Codes that use the bit-serial shifter rather than the one-cycle datapath.
    function automatic logic is_shift_op(input logic [2:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational add/sub/and/or/slt datapath.
// Unused codes (reserved 5 and the shift codes) produce zero.
module alu_single_cycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the operation result; add/sub wrap naturally at WIDTH bits.
    always_comb begin
        y = '0;
        case (alu_control)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Iterative ALU: one-cycle logic/arithmetic, bit-serial shifts (one position
// per cycle) under a start/busy/done handshake.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;     // 1 = logical right, 0 = left
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] shifted;

    alu_single_cycle #(.WIDTH(WIDTH)) u_single (
        .alu_control (alu_control),
        .a           (operand_a),
        .b           (operand_b),
        .y           (alu_y)
    );

    // One-bit step of the work register in the latched direction.
    assign shifted = dir_q ? (work_q >> 1) : (work_q << 1);

    // Next-state: accept in IDLE, step the shifter in SHIFT, pulse done on completion.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_shift_op(alu_control) && (shamt != '0)) begin
                        work_d  = operand_b;
                        cnt_d   = shamt;
                        dir_d   = (alu_control == ALU_SRL);
                        state_d = S_SHIFT;
                    end else begin
                        // A zero-distance shift passes operand_b straight through.
                        result_d = is_shift_op(alu_control) ? operand_b : alu_y;
                        zero_d   = (result_d == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign busy   = (state_q == S_SHIFT);
    assign done   = done_q;

endmodule
